imem_access_ctrl: RTL and testbench

- Initiator for the IMEM port (i_addr, wre, wr_data, i_data).
- Loads a block of instruction words into IMEM from a valid/ready stream.
- Later fetches a block back and emits it on a valid/ready output stream.
- Replaces manual VIO poking of IMEM for program loading and sequential instruction fetch; sits between the loader/core front-end and IMEM, on the IMEM clock.

---
 rtl/imem_access_pkg.sv | 21 ++
 rtl/imem_addr_gen.sv | 40 ++++
 rtl/imem_access_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_imem_access_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_access_pkg.sv
// Shared types and constants for the IMEM access controller.
// Optional checksum outputs are enabled in the top by defining IMEM_CHKSUM_EN.
package imem_access_pkg;

    // IMEM address and data width.
    localparam int IMEM_W = 32;

    // Default byte distance between consecutive instruction words.
    localparam int ADDR_STEP_DEF = 4;

    // Controller states.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        RD_ISSUE = 3'd2,
        RD_CAPT  = 3'd3,
        OUT_HOLD = 3'd4,
        FIN      = 3'd5
    } state_t;

endpackage

// File: rtl/imem_addr_gen.sv
// Word address / remaining-count tracker for one IMEM block transfer.
// Address arithmetic wraps modulo 2^32 through the natural register width.
module imem_addr_gen
    import imem_access_pkg::*;
#(
    parameter int ADDR_STEP = ADDR_STEP_DEF,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [IMEM_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_cnt,
    output logic [IMEM_W-1:0] cur_addr,
    output logic [CNT_W-1:0]  remaining,
    output logic              last,
    output logic              empty
);

    // Capture the block on start, then advance one word per completed transfer.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr  <= '0;
            remaining <= '0;
        end else if (load) begin
            cur_addr  <= base_addr;
            remaining <= word_cnt;
        end else if (step) begin
            cur_addr  <= cur_addr + IMEM_W'(ADDR_STEP);
            remaining <= remaining - CNT_W'(1);
        end
    end

    assign last  = (remaining == CNT_W'(1));
    assign empty = (remaining == '0);

endmodule

// File: rtl/imem_access_ctrl.sv
// IMEM initiator: loads a block of words from a valid/ready stream into IMEM,
// or fetches a block back and presents it on a valid/ready output stream.
// Define IMEM_CHKSUM_EN to add running-XOR outputs chk_wr / chk_rd.
module imem_access_ctrl
    import imem_access_pkg::*;
#(
    parameter int ADDR_STEP = ADDR_STEP_DEF,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_load,
    input  logic              start_fetch,
    input  logic [IMEM_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_cnt,
    input  logic [IMEM_W-1:0] ld_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    output logic [IMEM_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              busy,
    output logic              done,
    output logic [IMEM_W-1:0] i_addr,
    output logic              wre,
    output logic [IMEM_W-1:0] wr_data,
    input  logic [IMEM_W-1:0] i_data
`ifdef IMEM_CHKSUM_EN
    ,
    output logic [IMEM_W-1:0] chk_wr,
    output logic [IMEM_W-1:0] chk_rd
`endif
);

    state_t              state;
    state_t              state_nx;
    logic                ag_load;
    logic                ag_step;
    logic [IMEM_W-1:0]   cur_addr;
    logic [CNT_W-1:0]    remaining;
    logic                last;
    logic                empty;

    logic [IMEM_W-1:0]   i_addr_nx;
    logic                wre_nx;
    logic [IMEM_W-1:0]   wr_data_nx;
    logic [IMEM_W-1:0]   instr_nx;
    logic                instr_valid_nx;
    logic                ld_ready_nx;
    logic                busy_nx;
    logic                done_nx;

    imem_addr_gen #(
        .ADDR_STEP (ADDR_STEP),
        .CNT_W     (CNT_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ag_load),
        .step      (ag_step),
        .base_addr (base_addr),
        .word_cnt  (word_cnt),
        .cur_addr  (cur_addr),
        .remaining (remaining),
        .last      (last),
        .empty     (empty)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and next values of the registered outputs.
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_nx       = state;
        ag_load        = 1'b0;
        ag_step        = 1'b0;
        i_addr_nx      = i_addr;
        wre_nx         = 1'b0;
        wr_data_nx     = wr_data;
        instr_nx       = instr;
        instr_valid_nx = instr_valid;
        unique case (state)
            IDLE: begin
                // Load wins when both starts arrive together.
                if (start_load || start_fetch) begin
                    ag_load = 1'b1;
                    if (word_cnt == '0) begin
                        state_nx = FIN;
                    end else if (start_load) begin
                        state_nx = LOAD;
                    end else begin
                        state_nx  = RD_ISSUE;
                        i_addr_nx = base_addr;
                    end
                end
            end
            LOAD: begin
                if (ld_valid && ld_ready) begin
                    ag_step    = 1'b1;
                    wre_nx     = 1'b1;
                    i_addr_nx  = cur_addr;
                    wr_data_nx = ld_data;
                    if (last) begin
                        state_nx = FIN;
                    end
                end
            end
            RD_ISSUE: begin
                // i_addr is already on the bus; IMEM returns data next cycle.
                state_nx = RD_CAPT;
            end
            RD_CAPT: begin
                instr_nx       = i_data;
                instr_valid_nx = 1'b1;
                ag_step        = 1'b1;
                state_nx       = OUT_HOLD;
            end
            OUT_HOLD: begin
                if (instr_ready) begin
                    instr_valid_nx = 1'b0;
                    if (!empty) begin
                        state_nx  = RD_ISSUE;
                        i_addr_nx = cur_addr;
                    end else begin
                        state_nx = FIN;
                    end
                end
            end
            FIN: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign ld_ready_nx = (state_nx == LOAD);
    assign busy_nx     = (state_nx != IDLE);
    assign done_nx     = (state == FIN);

    // Output registers; reset drops wre and every other output immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_addr      <= '0;
            wre         <= 1'b0;
            wr_data     <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            ld_ready    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            i_addr      <= i_addr_nx;
            wre         <= wre_nx;
            wr_data     <= wr_data_nx;
            instr       <= instr_nx;
            instr_valid <= instr_valid_nx;
            ld_ready    <= ld_ready_nx;
            busy        <= busy_nx;
            done        <= done_nx;
        end
    end

`ifdef IMEM_CHKSUM_EN
    // Running XOR of words written by the current load / captured by the current fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_wr <= '0;
            chk_rd <= '0;
        end else begin
            if (state == IDLE && start_load) begin
                chk_wr <= '0;
            end else if (wre_nx) begin
                chk_wr <= chk_wr ^ ld_data;
            end
            if (state == IDLE && start_fetch && !start_load) begin
                chk_rd <= '0;
            end else if (state == RD_CAPT) begin
                chk_rd <= chk_rd ^ i_data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Self-checking bench for imem_access_ctrl: a transaction-level model (expected
// write list, reference memory, expected fetch list) checked every cycle, plus
// literal timing/value expectations in each directed test.
module tb_imem_access_ctrl;

    localparam int CNT_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_load = 1'b0;
    logic              start_fetch = 1'b0;
    logic [31:0]       base_addr = '0;
    logic [CNT_W-1:0]  word_cnt = '0;
    logic [31:0]       ld_data;
    logic              ld_valid = 1'b0;
    logic              ld_ready;
    logic [31:0]       instr;
    logic              instr_valid;
    logic              instr_ready = 1'b0;
    logic              busy;
    logic              done;
    logic [31:0]       i_addr;
    logic              wre;
    logic [31:0]       wr_data;
    logic [31:0]       i_data = '0;
`ifdef IMEM_CHKSUM_EN
    logic [31:0]       chk_wr;
    logic [31:0]       chk_rd;
`endif

    always #5 clk = ~clk;

    imem_access_ctrl #(.ADDR_STEP(4), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_load  (start_load),
        .start_fetch (start_fetch),
        .base_addr   (base_addr),
        .word_cnt    (word_cnt),
        .ld_data     (ld_data),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .busy        (busy),
        .done        (done),
        .i_addr      (i_addr),
        .wre         (wre),
        .wr_data     (wr_data),
        .i_data      (i_data)
`ifdef IMEM_CHKSUM_EN
        ,
        .chk_wr      (chk_wr),
        .chk_rd      (chk_rd)
`endif
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_wr[$];
    logic [31:0] exp_rd[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] imem    [logic [31:0]];

    int          wr_cyc_q[$];
    logic [31:0] wr_addr_q[$];
    int          hs_cyc_q[$];
    logic [31:0] hs_data_q[$];
    int          done_cyc_q[$];

    logic [31:0] ld_words [0:7];
    int          ld_idx = 0;
    int          t_start = 0;

    bit          stall_prev = 1'b0;
    logic [31:0] prev_instr = '0;
    logic [31:0] prev_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // IMEM: write on wre, synchronous read one cycle after i_addr.
    always @(posedge clk) begin
        if (wre) imem[i_addr] = wr_data;
        i_data <= imem.exists(i_addr) ? imem[i_addr] : 32'h0;
    end

    // Load stream source: present ld_words in order, advance on each handshake.
    always @(posedge clk) begin
        if (start_load) ld_idx <= 0;
        else if (ld_valid && ld_ready) ld_idx <= ld_idx + 1;
    end
    assign ld_data = ld_words[ld_idx[2:0]];

    // Compare process: check DUT activity against the model every cycle.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (wre) begin
                wr_cyc_q.push_back(cyc);
                wr_addr_q.push_back(i_addr);
                if (exp_wr.size() == 0) begin
                    check("spurious_wre", 32'(wre), 32'h0);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("wr_addr", i_addr, e.addr);
                    check("wr_data", wr_data, e.data);
                    ref_mem[e.addr] = e.data;
                end
            end
            if (stall_prev) begin
                check("hold_valid", 32'(instr_valid), 32'h1);
                check("hold_instr", instr, prev_instr);
                check("hold_addr", i_addr, prev_addr);
            end
            if (instr_valid && instr_ready) begin
                hs_cyc_q.push_back(cyc);
                hs_data_q.push_back(instr);
                if (exp_rd.size() == 0) check("spurious_instr", 32'(instr_valid), 32'h0);
                else check("instr_data", instr, exp_rd.pop_front());
            end
            if (done) begin
                done_cyc_q.push_back(cyc);
                check("busy_at_done", 32'(busy), 32'h0);
            end
            if (!busy) check("idle_quiet", {29'b0, wre, instr_valid, ld_ready}, 32'h0);
            stall_prev = instr_valid && !instr_ready;
            prev_instr = instr;
            prev_addr  = i_addr;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_traces();
        wr_cyc_q.delete();
        wr_addr_q.delete();
        hs_cyc_q.delete();
        hs_data_q.delete();
        done_cyc_q.delete();
    endtask

    task automatic model_load(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            wr_t e;
            e.addr = base + 32'(4 * i);
            e.data = ld_words[i];
            exp_wr.push_back(e);
        end
    endtask

    task automatic model_fetch(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] a;
            a = base + 32'(4 * i);
            exp_rd.push_back(ref_mem.exists(a) ? ref_mem[a] : 32'h0);
        end
    endtask

    task automatic start_op(input bit ld, input bit fe, input logic [31:0] base, input int n);
        base_addr   = base;
        word_cnt    = CNT_W'(n);
        start_load  = ld;
        start_fetch = fe;
        t_start     = cyc;
        step();
        start_load  = 1'b0;
        start_fetch = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k = 0;
        while (done_cyc_q.size() == 0 && k < budget) begin
            step();
            k++;
        end
        check({name, "_done_seen"}, 32'(done_cyc_q.size()), 32'd1);
        step();
        step();
        check({name, "_busy_after"}, 32'(busy), 32'h0);
        check({name, "_single_done"}, 32'(done_cyc_q.size()), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected end before 200000");
        $fatal(1);
    end

    initial begin
        int k;
        logic [31:0] held_instr;
        logic [31:0] held_addr;

        // Reset state.
        #3;
        check("rst_i_addr", i_addr, 32'h0);
        check("rst_wre", 32'(wre), 32'h0);
        check("rst_ld_ready", 32'(ld_ready), 32'h0);
        check("rst_instr_valid", 32'(instr_valid), 32'h0);
        check("rst_busy_done", {30'b0, busy, done}, 32'h0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Load 4 words at 0x10 with ld_valid held high.
        ld_words[0] = 32'h11111111; ld_words[1] = 32'h22222222;
        ld_words[2] = 32'h33333333; ld_words[3] = 32'h44444444;
        clear_traces();
        model_load(32'h10, 4);
        ld_valid = 1'b1;
        start_op(1'b1, 1'b0, 32'h10, 4);
        wait_done("load4", 20);
        ld_valid = 1'b0;
        check("load4_wr_count", 32'(wr_cyc_q.size()), 32'd4);
        for (int i = 1; i < 4; i++) check("load4_consecutive", 32'(wr_cyc_q[i] - wr_cyc_q[i-1]), 32'd1);
        check("load4_addr0", wr_addr_q[0], 32'h10);
        check("load4_addr3", wr_addr_q[3], 32'h1C);
        check("load4_done_after_wre", 32'(done_cyc_q[0] - wr_cyc_q[3]), 32'd1);
        check("load4_pending", 32'(exp_wr.size()), 32'd0);

        // Fetch 4 words back with instr_ready high.
        instr_ready = 1'b1;
        clear_traces();
        model_fetch(32'h10, 4);
        start_op(1'b0, 1'b1, 32'h10, 4);
        wait_done("fetch4", 40);
        check("fetch4_count", 32'(hs_cyc_q.size()), 32'd4);
        for (int i = 1; i < 4; i++) check("fetch4_spacing", 32'(hs_cyc_q[i] - hs_cyc_q[i-1]), 32'd3);
        check("fetch4_word0", hs_data_q[0], 32'h11111111);
        check("fetch4_word3", hs_data_q[3], 32'h44444444);
        check("fetch4_no_wre", 32'(wr_cyc_q.size()), 32'd0);
        check("fetch4_pending", 32'(exp_rd.size()), 32'd0);

        // Fetch with the consumer stalling 5 cycles on word 2.
        instr_ready = 1'b0;
        clear_traces();
        model_fetch(32'h10, 4);
        start_op(1'b0, 1'b1, 32'h10, 4);
        k = 0;
        while (!instr_valid && k < 10) begin step(); k++; end
        check("stall_w1_valid", 32'(instr_valid), 32'h1);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        k = 0;
        while (!instr_valid && k < 10) begin step(); k++; end
        check("stall_w2_valid", 32'(instr_valid), 32'h1);
        held_instr = instr;
        held_addr  = i_addr;
        check("stall_instr_lit", held_instr, 32'h22222222);
        check("stall_addr_lit", held_addr, 32'h14);
        repeat (5) begin
            step();
            check("stall_instr", instr, held_instr);
            check("stall_valid", 32'(instr_valid), 32'h1);
            check("stall_addr", i_addr, held_addr);
        end
        instr_ready = 1'b1;
        wait_done("fetch_stall", 40);
        check("fetch_stall_count", 32'(hs_cyc_q.size()), 32'd4);

        // word_cnt = 0: done two cycles after start, no writes.
        clear_traces();
        start_op(1'b1, 1'b0, 32'h100, 0);
        wait_done("cnt0", 10);
        check("cnt0_done_time", 32'(done_cyc_q[0] - t_start), 32'd3);
        check("cnt0_no_wre", 32'(wr_cyc_q.size()), 32'd0);

        // Both starts together: only the load is performed.
        ld_words[0] = 32'hCAFE0001; ld_words[1] = 32'hCAFE0002;
        clear_traces();
        model_load(32'h40, 2);
        ld_valid = 1'b1;
        start_op(1'b1, 1'b1, 32'h40, 2);
        wait_done("both", 20);
        ld_valid = 1'b0;
        check("both_wr_count", 32'(wr_cyc_q.size()), 32'd2);
        check("both_no_fetch", 32'(hs_cyc_q.size()), 32'd0);

        // Address wrap at the top of the address space.
        ld_words[0] = 32'h5A000001; ld_words[1] = 32'h5A000002; ld_words[2] = 32'h5A000003;
        clear_traces();
        model_load(32'hFFFFFFF8, 3);
        ld_valid = 1'b1;
        start_op(1'b1, 1'b0, 32'hFFFFFFF8, 3);
        wait_done("wrap", 20);
        ld_valid = 1'b0;
        check("wrap_addr0", wr_addr_q[0], 32'hFFFFFFF8);
        check("wrap_addr1", wr_addr_q[1], 32'hFFFFFFFC);
        check("wrap_addr2", wr_addr_q[2], 32'h00000000);

        // Reset in the middle of a 4-word load after 2 words.
        ld_words[0] = 32'hB0000001; ld_words[1] = 32'hB0000002;
        ld_words[2] = 32'hB0000003; ld_words[3] = 32'hB0000004;
        clear_traces();
        model_load(32'h80, 4);
        ld_valid = 1'b1;
        start_op(1'b1, 1'b0, 32'h80, 4);
        k = 0;
        while (wr_cyc_q.size() < 2 && k < 10) begin step(); k++; end
        check("abort_two_written", 32'(wr_cyc_q.size()), 32'd2);
        rst_n = 1'b0;
        #1;
        check("abort_wre", 32'(wre), 32'h0);
        check("abort_i_addr", i_addr, 32'h0);
        check("abort_wr_data", wr_data, 32'h0);
        check("abort_instr", instr, 32'h0);
        check("abort_flags", {28'b0, instr_valid, ld_ready, busy, done}, 32'h0);
        exp_wr.delete();
        ld_valid = 1'b0;
        step();
        step();
        clear_traces();
        rst_n = 1'b1;
        repeat (6) step();
        check("abort_no_done", 32'(done_cyc_q.size()), 32'd0);
        check("abort_idle", 32'(busy), 32'h0);

        // Fetch after the abort: two words landed, the third never did.
        clear_traces();
        model_fetch(32'h80, 3);
        start_op(1'b0, 1'b1, 32'h80, 3);
        wait_done("post_abort", 40);
        check("post_abort_count", 32'(hs_cyc_q.size()), 32'd3);
        check("post_abort_w1", hs_data_q[1], 32'hB0000002);
        check("post_abort_w2", hs_data_q[2], 32'h00000000);

`ifdef IMEM_CHKSUM_EN
        // Checksums over a load and the matching fetch.
        ld_words[0] = 32'hA5A5A5A5; ld_words[1] = 32'h0F0F0F0F;
        clear_traces();
        model_load(32'h200, 2);
        ld_valid = 1'b1;
        start_op(1'b1, 1'b0, 32'h200, 2);
        wait_done("chk_load", 20);
        ld_valid = 1'b0;
        clear_traces();
        model_fetch(32'h200, 2);
        start_op(1'b0, 1'b1, 32'h200, 2);
        wait_done("chk_fetch", 40);
        repeat (3) step();
        check("chk_wr", chk_wr, ld_words[0] ^ ld_words[1]);
        check("chk_rd", chk_rd, 32'hAAAAAAAA);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
